// File: rtl/reg10_arbiter_ctrl_pkg.sv
// Shared definitions for the two-requester arbiter / 10-bit holding register.
//   DEF_WIDTH, DEF_CNT_W : default data and conflict-counter widths
//   state_e              : holding-register occupancy (EMPTY / FULL)
//   SRC0, SRC1           : requester IDs used for q_src and last_gnt
package reg10_arbiter_ctrl_pkg;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;
endpackage

// File: rtl/reg10_arbiter_ctrl_if.sv
// Request/grant and downstream valid/ready bundle of the arbiter.
//   req0/data0/gnt0, req1/data1/gnt1 : requester side
//   q_out/q_valid/q_src/q_ready      : consumer side
// master = producers + consumer, slave = arbiter.
interface reg10_arbiter_ctrl_if
  import reg10_arbiter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             gnt0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt1;
  logic [WIDTH-1:0] q_out;
  logic             q_valid;
  logic             q_src;
  logic             q_ready;

  modport master (
    output req0, data0, req1, data1, q_ready,
    input  gnt0, gnt1, q_out, q_valid, q_src
  );

  modport slave (
    input  req0, data0, req1, data1, q_ready,
    output gnt0, gnt1, q_out, q_valid, q_src
  );
endinterface

// File: rtl/reg10_arbiter_ctrl_register_en_w.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
//   clk, rst : clock, synchronous reset (clears q)
//   en, d    : load enable and next value
//   q        : registered value
module register_en_w #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/reg10_arbiter_ctrl.sv
// Round-robin arbiter for two requesters feeding one 10-bit holding register
// with a valid/ready output and a saturating conflict counter.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : requests/grants in, q_out/q_valid/q_src/q_ready out
//   conflict_cnt : grants issued while both requests were high (saturating)
module reg10_arbiter_ctrl
  import reg10_arbiter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  reg10_arbiter_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]     conflict_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  logic             last_gnt;
  logic             src;
  logic             can_load;
  logic             both;
  logic             g0, g1, load;
  logic [WIDTH-1:0] win_data;

  // A pop and a load may share an edge, so FULL && q_ready still accepts.
  assign can_load = (state == ST_EMPTY) || bus.q_ready;
  assign both     = bus.req0 && bus.req1;

  // On a conflict the requester that did not win last time gets the grant.
  assign g0   = !rst && can_load && bus.req0 && (!bus.req1 || last_gnt == SRC1);
  assign g1   = !rst && can_load && bus.req1 && (!bus.req0 || last_gnt == SRC0);
  assign load = g0 || g1;

  assign win_data = g1 ? bus.data1 : bus.data0;

  assign bus.gnt0    = g0;
  assign bus.gnt1    = g1;
  assign bus.q_valid = (state == ST_FULL);
  assign bus.q_src   = src;

  register_en_w #(.WIDTH(WIDTH)) u_hold (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   (win_data),
    .q   (bus.q_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      src          <= SRC0;
      last_gnt     <= SRC1;  // requester 0 wins the first conflict
      conflict_cnt <= '0;
    end else if (load) begin
      state    <= ST_FULL;
      src      <= g1 ? SRC1 : SRC0;
      last_gnt <= g1 ? SRC1 : SRC0;
      if (both && conflict_cnt != CNT_MAX)
        conflict_cnt <= conflict_cnt + CNT_ONE;
    end else if (state == ST_FULL && bus.q_ready) begin
      // Consumed with nothing to replace it: q_out/q_src keep last values.
      state <= ST_EMPTY;
    end
  end
endmodule

// File: tb/tb_reg10_arbiter_ctrl.sv
// Bench for reg10_arbiter_ctrl: a slot-level model checked every cycle,
// plus directed sequences with literal expected values.
module tb_reg10_arbiter_ctrl;
  import reg10_arbiter_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  reg10_arbiter_ctrl_if bus ();
  reg10_arbiter_ctrl_if bus2 ();

  reg10_arbiter_ctrl #(.WIDTH(10), .CNT_W(8)) dut (
    .clk (clk), .rst (rst), .bus (bus), .conflict_cnt (cnt8)
  );

  // Narrow-counter copy fed with identical stimulus to exercise saturation.
  reg10_arbiter_ctrl #(.WIDTH(10), .CNT_W(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2), .conflict_cnt (cnt2)
  );
  assign bus2.req0    = bus.req0;
  assign bus2.data0   = bus.data0;
  assign bus2.req1    = bus.req1;
  assign bus2.data1   = bus.data1;
  assign bus2.q_ready = bus.q_ready;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: a single slot holding {data, src}, plus whoever won last and an
  // unbounded conflict tally.
  bit         m_valid = 0;
  logic [9:0] m_data  = '0;
  bit         m_src   = 0;
  bit         m_last  = 1;
  int         m_conf  = 0;
  bit         chk_en  = 0;

  // Which requester the rules say gets the slot this cycle ({gnt1, gnt0}).
  function automatic logic [1:0] pick();
    if (rst) return 2'b00;
    if (m_valid && !bus.q_ready) return 2'b00;
    if (bus.req0 && bus.req1) return m_last ? 2'b01 : 2'b10;
    return {bus.req1, bus.req0};
  endfunction

  logic [1:0] mg;
  always @(posedge clk) begin
    mg = pick();
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_conf = 0;
    end else if (mg != 2'b00) begin
      if (bus.req0 && bus.req1) m_conf++;
      m_valid = 1;
      m_src   = mg[1];
      m_last  = mg[1];
      m_data  = mg[1] ? bus.data1 : bus.data0;
    end else if (bus.q_ready) begin
      m_valid = 0;
    end
  end

  logic [1:0] cg;
  always @(negedge clk) begin
    if (chk_en) begin
      cg = pick();
      check("gnt0", bus.gnt0, cg[0]);
      check("gnt1", bus.gnt1, cg[1]);
      check("q_valid", bus.q_valid, m_valid);
      check("q_out", bus.q_out, m_data);
      check("q_src", bus.q_src, m_src);
      check("cnt8", cnt8, (m_conf > 255) ? 255 : m_conf);
      check("cnt2", cnt2, (m_conf > 3) ? 3 : m_conf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b1; bus.data0 = 10'h155;
    bus.req1 = 1'b0; bus.data1 = '0;
    bus.q_ready = 1'b1;

    // Reset held two cycles with a live request.
    tick();
    chk_en = 1;
    #1;
    check("rst_gnt0_a", bus.gnt0, 1'b0);
    check("rst_qv_a", bus.q_valid, 1'b0);
    check("rst_qout_a", bus.q_out, 10'h000);
    check("rst_cnt_a", cnt8, 8'd0);
    tick();
    check("rst_gnt0_b", bus.gnt0, 1'b0);
    check("rst_qv_b", bus.q_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_gnt0", bus.gnt0, 1'b1);
    tick();
    check("rel_qout", bus.q_out, 10'h155);
    check("rel_qsrc", bus.q_src, 1'b0);
    check("rel_qv", bus.q_valid, 1'b1);
    bus.req0 = 1'b0;

    // Round-robin from a fresh reset, also driving the narrow counter to saturation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.data0 = 10'h0AA;
    bus.req1 = 1'b1; bus.data1 = 10'h311;
    #1;
    check("rr_first_gnt0", bus.gnt0, 1'b1);
    check("rr_first_gnt1", bus.gnt1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_qout", bus.q_out, (i % 2 == 0) ? 10'h0AA : 10'h311);
      check("rr_qsrc", bus.q_src, (i % 2 == 0) ? 1'b0 : 1'b1);
      check("rr_cnt8", cnt8, i + 1);
      check("rr_cnt2", cnt2, (i + 1 > 3) ? 3 : i + 1);
    end

    // Backpressure.
    bus.req0 = 1'b0;
    bus.data1 = 10'h3FF;
    tick();
    check("bp_load", bus.q_out, 10'h3FF);
    bus.q_ready = 1'b0;
    bus.data1 = 10'h2AB;
    #1;
    check("bp_gnt1_hold", bus.gnt1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_qout", bus.q_out, 10'h3FF);
      check("bp_qv", bus.q_valid, 1'b1);
      check("bp_gnt1", bus.gnt1, 1'b0);
    end
    bus.q_ready = 1'b1;
    #1;
    check("bp_release_gnt1", bus.gnt1, 1'b1);
    tick();
    check("bp_next_qout", bus.q_out, 10'h2AB);
    check("bp_next_qv", bus.q_valid, 1'b1);
    bus.req1 = 1'b0;

    // Drain.
    tick();
    check("drain_empty", bus.q_valid, 1'b0);
    bus.req0 = 1'b1; bus.data0 = 10'h001;
    tick();
    check("drain_qv1", bus.q_valid, 1'b1);
    check("drain_qout1", bus.q_out, 10'h001);
    bus.req0 = 1'b0;
    tick();
    check("drain_qv0", bus.q_valid, 1'b0);
    check("drain_qout_hold", bus.q_out, 10'h001);

    // Reset mid-operation while FULL and stalled; last winner was requester 0.
    bus.req0 = 1'b1; bus.data0 = 10'h0F0;
    tick();
    bus.req0 = 1'b0;
    bus.q_ready = 1'b0;
    tick();
    check("mid_full", bus.q_valid, 1'b1);
    rst = 1'b1;
    bus.req0 = 1'b1; bus.data0 = 10'h123;
    bus.req1 = 1'b1; bus.data1 = 10'h234;
    #1;
    check("mid_rst_gnt0", bus.gnt0, 1'b0);
    check("mid_rst_gnt1", bus.gnt1, 1'b0);
    tick();
    check("mid_qv", bus.q_valid, 1'b0);
    check("mid_qout", bus.q_out, 10'h000);
    check("mid_cnt", cnt8, 8'd0);
    rst = 1'b0;
    #1;
    check("mid_gnt0", bus.gnt0, 1'b1);
    check("mid_gnt1", bus.gnt1, 1'b0);
    tick();
    check("mid_win_qout", bus.q_out, 10'h123);
    check("mid_win_qsrc", bus.q_src, 1'b0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.q_ready = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg10_arbiter_ctrl.md
# reg10_arbiter_ctrl

Two-requester round-robin arbiter and controller for a shared 10-bit holding register. Each requester presents a 10-bit word with a request; the block grants one per cycle, loads the winning word into the register, and presents it downstream with a valid/ready handshake. It sits between the input-side producers and the consumer of the 10-bit register datapath, and keeps a saturating count of arbitration conflicts for debug.

## Interface
- WIDTH, 10, data width of the requester words and the holding register
- CNT_W, 8, width of the saturating conflict counter

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- req0  in  1  requester 0 request; held with data0 until gnt0 is seen high at a rising edge
- data0  in  WIDTH  requester 0 word
- gnt0  out  1  combinational; high in the cycle data0 is captured at the next edge
- req1  in  1  requester 1 request; same rules as req0
- data1  in  WIDTH  requester 1 word
- gnt1  out  1  combinational; high in the cycle data1 is captured at the next edge
- q_out  out  WIDTH  registered word
- q_valid  out  1  q_out holds an unconsumed word
- q_src  out  1  source of q_out: 0 = requester 0, 1 = requester 1
- q_ready  in  1  consumer accepts q_out at a rising edge when q_valid && q_ready
- conflict_cnt  out  CNT_W  count of grants issued while both requests were high; saturates

## Operation
- Two states: EMPTY (q_valid=0) and FULL (q_valid=1).
- can_load = EMPTY || (FULL && q_ready). Grants are issued only when can_load is true.
- Arbitration when can_load is true:
  - Only req0 high: gnt0=1.
  - Only req1 high: gnt1=1.
  - Both high: grant the requester that is not last_gnt.
- At most one of gnt0/gnt1 is high; neither is high when rst=1.
- On a granted edge:
  - q_out <= winning data.
  - q_src <= winner.
  - last_gnt <= winner.
  - State becomes FULL.
- Transitions:
  - EMPTY, no grant: stay EMPTY.
  - FULL && q_ready, no grant: go to EMPTY; q_out and q_src hold their last values.
  - FULL && !q_ready: hold everything; no grants.
- conflict_cnt increments by 1 on every granted edge where req0 && req1. It holds at 2^CNT_W-1.
- Reset values: state EMPTY, q_valid=0, q_out=0, q_src=0, last_gnt=1 (requester 0 wins the first conflict), conflict_cnt=0.
- Reset mid-operation: rst overrides every other event in its cycle. Any pending word is discarded and no grant is issued. Requesters see no gnt and must keep requesting.

## Timing
- Latency: request accepted at edge N (gnt high in cycle N-1) gives q_valid=1 with the new q_out from edge N. One cycle from grant to output.
- Throughput: one word per cycle when q_ready is held high, because a pop and a load occur on the same edge.
- gnt0/gnt1 depend combinationally on req0, req1, state, q_ready and last_gnt. There is no combinational path from data0/data1 to any output.
- Backpressure: while FULL && !q_ready, gnt0=gnt1=0 and q_out, q_src and q_valid are stable.
- Requests must not be withdrawn before a grant is seen. Behaviour under withdrawal is defined only as "no grant to an absent request".

## Structure
- Shared package/include holds:
  - WIDTH and CNT_W defaults.
  - State encodings ST_EMPTY=1'b0 and ST_FULL=1'b1.
  - Source IDs SRC0=1'b0 and SRC1=1'b1.
- One sub-module, register_en_w: a WIDTH-bit register with synchronous reset and load enable. It holds q_out and is instantiated once, with its load enable driven by the grant logic.
- Arbitration, the state register, last_gnt, q_src and conflict_cnt live in the top module.

## Test plan
- Reset: assert rst for 2 cycles with req0=1, data0=10'h155 -> gnt0=0 throughout, q_valid=0, q_out=0, conflict_cnt=0. On release, gnt0=1 next cycle and q_out=10'h155, q_src=0 one edge later.
- Round-robin: req0=req1=1 continuously, data0=10'h0AA, data1=10'h311, q_ready=1 -> q_out alternates 0AA, 311, 0AA… starting with 0AA; conflict_cnt increments by 1 per cycle.
- Backpressure: load 10'h3FF, hold q_ready=0 for 5 cycles with req1=1 -> q_out stays 3FF, q_valid=1, gnt1=0. Raise q_ready -> gnt1=1 in that cycle and the new word appears on the next edge without an empty cycle.
- Drain: single word 10'h001 with q_ready=1 and no further requests -> q_valid high for exactly one cycle, then 0 with q_out still 10'h001.
- Saturation: CNT_W=2 with both requests held for 6 grants -> conflict_cnt reads 1,2,3,3,3,3.
- Reset mid-operation: rst=1 for one cycle while FULL with q_ready=0 -> q_valid=0 and q_out=0 next cycle, last_gnt back to 1, so the next conflict is won by requester 0.
